// File: rtl/divide_re_extra_shift.sv
// rtl/divide_re_extra_shift.sv - sequential signed fixed-point divider q = sat((a << WIDTH) / b)
module divide_re_extra_shift #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] b_re,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_re,
  output logic             ovf,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   b_mag;
  logic             sign, zero, pre_ovf, a_neg;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic             accept, calc_last;
  logic [WIDTH:0]   a_ext, b_ext, a_abs, b_abs;
  logic [WIDTH+1:0] rem_sh;
  logic             ge;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] q_fin;
  logic             ovf_fin, dz_fin;

  assign accept    = in_valid && in_ready;
  // Counter runs 0..WIDTH-1 for the iterations; the extra step at WIDTH registers the result.
  assign calc_last = (cnt == CW'(WIDTH));

  // Magnitudes are one bit wider so the most-negative input has a representable absolute value.
  always_comb begin
    a_ext = {a_re[WIDTH-1], a_re};
    b_ext = {b_re[WIDTH-1], b_re};
    a_abs = a_re[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
    b_abs = b_re[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;
  end

  // One restoring step; the low dividend bits are all zero, so only zeros are shifted in.
  always_comb begin
    rem_sh  = {rem, 1'b0};
    ge      = (rem_sh >= {1'b0, b_mag});
    rem_nxt = ge ? (WIDTH+1)'(rem_sh - {1'b0, b_mag}) : rem_sh[WIDTH:0];
  end

  // Result selection in priority order: divide-by-zero, pre-detected overflow, then range saturation.
  always_comb begin
    q_fin   = '0;
    ovf_fin = 1'b0;
    dz_fin  = 1'b0;
    if (zero) begin
      q_fin  = a_neg ? MAX_NEG : MAX_POS;
      dz_fin = 1'b1;
    end else if (pre_ovf) begin
      q_fin   = sign ? MAX_NEG : MAX_POS;
      ovf_fin = 1'b1;
    end else if (!sign && (quo > MAX_POS)) begin
      q_fin   = MAX_POS;
      ovf_fin = 1'b1;
    end else if (sign && (quo > MAX_NEG)) begin
      q_fin   = MAX_NEG;
      ovf_fin = 1'b1;
    end else begin
      q_fin = sign ? (~quo + 1'b1) : quo;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand latch, iteration datapath and registered result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_mag    <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      pre_ovf  <= 1'b0;
      a_neg    <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      q_re     <= '0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      b_mag   <= b_abs;
      sign    <= a_re[WIDTH-1] ^ b_re[WIDTH-1];
      zero    <= (b_re == '0);
      pre_ovf <= (a_abs >= b_abs);
      a_neg   <= a_re[WIDTH-1];
      rem     <= a_abs;
      quo     <= '0;
      cnt     <= '0;
    end else if (state == CALC) begin
      if (calc_last) begin
        q_re     <= q_fin;
        ovf      <= ovf_fin;
        div_zero <= dz_fin;
      end else begin
        rem <= rem_nxt;
        quo <= {quo[WIDTH-2:0], ge};
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_divide_re_extra_shift.sv
// tb/tb_divide_re_extra_shift.sv - directed self-checking bench for divide_re_extra_shift
module tb_divide_re_extra_shift;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_re = '0;
  logic [15:0] b_re = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] q_re;
  logic        ovf;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  divide_re_extra_shift #(.WIDTH(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_re     (a_re),
    .b_re     (b_re),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q_re     (q_re),
    .ovf      (ovf),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b);
    int w = 0;
    @(negedge clock);
    while (!in_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    a_re     = a;
    b_re     = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    do begin
      @(posedge clock);
      #1 n++;
    end while (!out_valid && n < 40);
    check({tag, " latency"}, 32'(n), 32'd17);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] q,
                               input logic o, input logic d);
    check({tag, " q"}, 32'(q_re), 32'(q));
    check({tag, " ovf"}, 32'(ovf), 32'(o));
    check({tag, " div_zero"}, 32'(div_zero), 32'(d));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check({tag, " idle after drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] q, input logic o, input logic d);
    start(a, b);
    wait_result(tag);
    expect_result(tag, q, o, d);
    drain(tag);
  endtask

  initial begin
    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset q", 32'(q_re), 32'd0);
    check("reset flags", {30'd0, ovf, div_zero}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run("basic",     16'h1000, 16'h4000, 16'h4000, 1'b0, 1'b0);
    run("neg_a",     16'hF000, 16'h4000, 16'hC000, 1'b0, 1'b0);
    run("third",     16'h0001, 16'h0003, 16'h5555, 1'b0, 1'b0);
    run("neg_third", 16'hFFFF, 16'h0003, 16'hAAAB, 1'b0, 1'b0);
    run("neg_b",     16'h0001, 16'hFFFD, 16'hAAAB, 1'b0, 1'b0);
    run("sat_pos",   16'h2000, 16'h4000, 16'h7FFF, 1'b1, 1'b0);
    run("exact_neg", 16'hE000, 16'h4000, 16'h8000, 1'b0, 1'b0);
    run("pre_ovf",   16'h4000, 16'h4000, 16'h7FFF, 1'b1, 1'b0);
    run("min_a",     16'h8000, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
    run("dz_pos",    16'h0005, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
    run("dz_neg",    16'hFFFB, 16'h0000, 16'h8000, 1'b0, 1'b1);
    run("dz_zero",   16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1);

    // Back-pressure: result must hold while a new request waits.
    start(16'h1000, 16'h4000);
    wait_result("hold");
    a_re     = 16'h0001;
    b_re     = 16'h0003;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      expect_result("hold", 16'h4000, 1'b0, 1'b0);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("release state", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    check("pending accepted", 32'(in_ready), 32'd0);
    wait_result("pending");
    expect_result("pending", 16'h5555, 1'b0, 1'b0);
    drain("pending");

    // Leave nonzero outputs behind so the reset clearing is visible.
    run("dz_before_rst", 16'h0005, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
    start(16'hF000, 16'h4000);
    repeat (6) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort q", 32'(q_re), 32'd0);
    check("abort flags", {30'd0, ovf, div_zero}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run("after_rst", 16'h1000, 16'h4000, 16'h4000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
